// File: rtl/load_store_unit.sv
// RV32I load/store unit: bridges the core's EXECUTE stage to the word-addressed SOC bus,
// handling lane selection, store replication, byte masks, load extension and timeouts.
module load_store_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            legal, aligned, busy;
    logic [31:0]     load_fmt;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin
        legal = req_store ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (req_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = mem_rdata;
        endcase
    end

    assign busy = store_q ? mem_wbusy : mem_rbusy;

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    lane_d   = req_addr[1:0];
                    addr_d   = {req_addr[31:2], 2'b00};
                    cnt_d    = '0;
                    case (req_funct3[1:0])
                        2'b00: begin
                            wdata_d = {4{req_wdata[7:0]}};
                            wmask_d = 4'b0001 << req_addr[1:0];
                        end
                        2'b01: begin
                            wdata_d = {2{req_wdata[15:0]}};
                            wmask_d = 4'b0011 << {req_addr[1], 1'b0};
                        end
                        default: begin
                            wdata_d = req_wdata;
                            wmask_d = 4'b1111;
                        end
                    endcase
                    if (legal && aligned) begin
                        state_d = ACCESS;
                    end else begin
                        // Rejected requests go straight to RESP; memory never sees them.
                        state_d = RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: state_d = WAIT;
            WAIT: begin
                if (!busy) begin
                    state_d = RESP;
                    rdata_d = store_q ? 32'h0 : load_fmt;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            lane_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE) && !reset;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rstrb = (state_q == ACCESS) && !store_q;
    assign mem_wmask = ((state_q == ACCESS) && store_q) ? wmask_q : 4'b0000;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses, a monitor
// pops and compares each rsp_valid pulse and tracks memory strobes.
module tb_load_store_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rbusy, mem_wbusy;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data registered on the strobe, busy for a programmable count.
    logic [31:0] mem [0:255];
    int rd_cnt = 0, wr_cnt = 0, rbusy_n = 0, wbusy_n = 0;
    bit stuck = 1'b0;
    always @(posedge clk) begin
        if (mem_rstrb) begin
            mem_rdata <= mem[mem_addr[9:2]];
            rd_cnt    <= rbusy_n;
        end else if (rd_cnt > 0) begin
            rd_cnt <= rd_cnt - 1;
        end
        if (mem_wmask != 4'b0000) wr_cnt <= wbusy_n;
        else if (wr_cnt > 0)      wr_cnt <= wr_cnt - 1;
    end
    assign mem_rbusy = stuck || (rd_cnt != 0);
    assign mem_wbusy = (wr_cnt != 0);

    int n_vec = 0, n_bad = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    int          rd_pulses = 0, wr_pulses = 0;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
    logic [3:0]  last_wmask = 4'h0;

    always @(negedge clk) begin
        exp_t e;
        if (mem_rstrb) begin
            rd_pulses++;
            last_addr = mem_addr;
        end
        if (mem_wmask != 4'b0000) begin
            wr_pulses++;
            last_addr  = mem_addr;
            last_wmask = mem_wmask;
            last_wdata = mem_wdata;
        end
        if (!reset && rsp_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
                // latency counted in posedges after the accepting edge
                check("rsp_latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int lat, input logic [3:0] emask, input logic [31:0] ewd,
                         input bit hold);
        int rp0, wp0, k;
        exp_t e;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_issue", {31'h0, req_ready}, 32'd1);
        rp0 = rd_pulses;
        wp0 = wr_pulses;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        e.rdata = er; e.err = ee; e.lat = lat; e.acc = cyc;
        q.push_back(e);
        if (hold) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!rsp_valid && k < 100);
        end else begin
            @(negedge clk);
        end
        req_valid = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rsp_arrived", q.size(), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        if (ee) begin
            if (lat == 0) check("no_strobe_on_error", rd_pulses - rp0 + wr_pulses - wp0, 32'd0);
        end else if (!st) begin
            check("rstrb_pulses", rd_pulses - rp0, 32'd1);
            check("load_no_wmask", wr_pulses - wp0, 32'd0);
            check("load_mem_addr", last_addr, {a[31:2], 2'b00});
        end else begin
            check("wmask_pulses", wr_pulses - wp0, 32'd1);
            check("store_no_rstrb", rd_pulses - rp0, 32'd0);
            check("store_mem_addr", last_addr, {a[31:2], 2'b00});
            check("store_wmask", {28'h0, last_wmask}, {28'h0, emask});
            check("store_wdata", last_wdata, ewd);
        end
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", {31'h0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'h0, req_ready}, 32'd1);
        check("rsp_valid_reset", {31'h0, rsp_valid}, 32'd0);
        check("rsp_rdata_reset", rsp_rdata, 32'd0);
        check("mem_addr_reset", mem_addr, 32'd0);
        check("mem_strobes_reset", {27'h0, mem_rstrb, mem_wmask}, 32'd0);

        mem[8'h40] = 32'h80FF_1234;
        issue(0, 3'b000, 32'h103, 0, 32'hFFFF_FF80, 0, 2, 0, 0, 0);          // LB
        mem[8'h40] = 32'h8001_7FFF;
        issue(0, 3'b101, 32'h102, 0, 32'h0000_8001, 0, 2, 0, 0, 0);          // LHU
        issue(0, 3'b001, 32'h102, 0, 32'hFFFF_8001, 0, 2, 0, 0, 0);          // LH
        issue(0, 3'b100, 32'h101, 0, 32'h0000_007F, 0, 2, 0, 0, 0);          // LBU
        issue(0, 3'b000, 32'h100, 0, 32'hFFFF_FFFF, 0, 2, 0, 0, 0);          // LB
        issue(0, 3'b001, 32'h100, 0, 32'h0000_7FFF, 0, 2, 0, 0, 0);          // LH low
        issue(1, 3'b001, 32'h206, 32'hDEAD_BEEF, 0, 0, 2, 4'b1100, 32'hBEEF_BEEF, 0);
        issue(1, 3'b000, 32'h201, 32'hDEAD_BEEF, 0, 0, 2, 4'b0010, 32'hEFEF_EFEF, 0);
        wbusy_n = 2;
        issue(1, 3'b010, 32'h208, 32'hDEAD_BEEF, 0, 0, 4, 4'b1111, 32'hDEAD_BEEF, 0);
        wbusy_n = 0;
        // rejected requests: misaligned LW/SH, illegal load and store funct3
        issue(0, 3'b010, 32'h102, 0, 0, 1, 0, 0, 0, 0);
        issue(0, 3'b011, 32'h100, 0, 0, 1, 0, 0, 0, 0);
        issue(1, 3'b100, 32'h100, 32'h1234_5678, 0, 1, 0, 0, 0, 0);
        issue(1, 3'b001, 32'h203, 32'h1234_5678, 0, 1, 0, 0, 0, 0);
        // LW with 5 busy cycles, then with busy stuck until timeout
        rbusy_n = 5;
        issue(0, 3'b010, 32'h100, 0, 32'h8001_7FFF, 0, 7, 0, 0, 0);
        rbusy_n = 0;
        stuck = 1'b1;
        issue(0, 3'b010, 32'h100, 0, 32'h0, 1, TO + 1, 0, 0, 0);
        // Reset while waiting: no response, ready right after reset releases
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_midreset", {31'h0, req_ready}, 32'd1);
        check("strobes_after_midreset", {27'h0, mem_rstrb, mem_wmask}, 32'd0);
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        issue(0, 3'b010, 32'h100, 0, 32'h8001_7FFF, 0, 2, 0, 0, 0);
        // req_valid held through RESP must yield one response only
        issue(0, 3'b100, 32'h103, 0, 32'h0000_0080, 0, 2, 0, 0, 1);
        issue(0, 3'b011, 32'h100, 0, 0, 1, 0, 0, 0, 1);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
